// File: rtl/mel_group_accum.sv
// mel_group_accum
// ---------------------------------------------------------------------------
// Accumulates the power samples of one mel group (band) and emits one sum per
// group to the log stage, with a frame-done pulse on the final band. Group
// framing is checked; violations drop the offending beat or partial group and
// pulse proto_err.
//
// Handshake: no backpressure. A beat is accepted on every rising clk edge where
// di_en is high. Results are presented with a single-cycle do_en strobe; the
// data_o / out_group_num / out_bin_cnt fields hold until the next result.
//
// Ports
//   clk           : clock, rising edge
//   rst           : asynchronous reset, active low
//   di_en         : input beat valid
//   data_i        : signed power sample (negative treated as 0)
//   in_group_idx  : FFT bin index, informational only
//   in_group_num  : mel group number of the beat
//   is_first_in   : first beat of a group
//   is_last_in    : last beat of a group
//   do_en         : one-cycle result strobe
//   data_o        : accumulated group sum (unsigned)
//   out_group_num : group number of the result
//   out_bin_cnt   : beats accumulated, saturating at 1023
//   frame_done    : pulses with do_en when the result is for LAST_GROUP
//   proto_err     : one-cycle framing-violation pulse
//   dbg_state     : current FSM state (0 = IDLE, 1 = ACCUM)
//
// Build option: define MEL_ACC_SAT_EN to make the accumulator saturate at
// 2^ACC_BW-1 instead of wrapping.
// ---------------------------------------------------------------------------
module mel_group_accum #(
  parameter int I_BW       = 14,
  parameter int ACC_BW     = 24,
  parameter int LAST_GROUP = 88
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   di_en,
  input  logic signed [I_BW-1:0] data_i,
  input  logic [9:0]             in_group_idx,
  input  logic [6:0]             in_group_num,
  input  logic                   is_first_in,
  input  logic                   is_last_in,
  output logic                   do_en,
  output logic [ACC_BW-1:0]      data_o,
  output logic [6:0]             out_group_num,
  output logic [9:0]             out_bin_cnt,
  output logic                   frame_done,
  output logic                   proto_err,
  output logic [0:0]             dbg_state
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ACCUM = 1'b1;

  // Wide enough to hold the sample magnitude before resizing to ACC_BW.
  localparam int W_EXT = (I_BW > ACC_BW) ? I_BW : ACC_BW;

  logic [0:0]        r_state;
  logic [ACC_BW-1:0] r_acc;
  logic [9:0]        r_cnt;
  logic [6:0]        r_grp;

  logic [W_EXT-1:0]  w_ext;
  logic [ACC_BW-1:0] w_sample;
  logic [ACC_BW-1:0] w_sum;
  logic [9:0]        w_cnt_inc;

  logic [0:0]        w_nxt_state;
  logic [ACC_BW-1:0] w_nxt_acc;
  logic [9:0]        w_nxt_cnt;
  logic [6:0]        w_nxt_grp;
  logic              w_emit;
  logic              w_err;

  // The bin index only travels along for simulation display.
  logic w_unused_idx;
  assign w_unused_idx = ^in_group_idx;

  // Negative power (rounding artefacts upstream) contributes nothing.
  assign w_ext    = W_EXT'(data_i[I_BW-2:0]);
  assign w_sample = data_i[I_BW-1] ? '0 : w_ext[ACC_BW-1:0];

`ifdef MEL_ACC_SAT_EN
  logic [ACC_BW:0] w_wide_sum;
  assign w_wide_sum = {1'b0, r_acc} + {1'b0, w_sample};
  // Samples are non-negative, so once at full scale the sum stays there.
  assign w_sum = w_wide_sum[ACC_BW] ? '1 : w_wide_sum[ACC_BW-1:0];
`else
  assign w_sum = r_acc + w_sample;
`endif

  assign w_cnt_inc = (r_cnt == 10'd1023) ? r_cnt : r_cnt + 10'd1;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_acc   = r_acc;
    w_nxt_cnt   = r_cnt;
    w_nxt_grp   = r_grp;
    w_emit      = 1'b0;
    w_err       = 1'b0;
    if (di_en) begin
      if (is_first_in) begin
        // A first beat always starts a new group; in ACCUM it also throws
        // away the unfinished one.
        w_err       = (r_state == S_ACCUM);
        w_nxt_acc   = w_sample;
        w_nxt_cnt   = 10'd1;
        w_nxt_grp   = in_group_num;
        w_emit      = is_last_in;
        w_nxt_state = is_last_in ? S_IDLE : S_ACCUM;
      end else if (r_state == S_IDLE) begin
        w_err = 1'b1;
      end else if (in_group_num != r_grp) begin
        w_err = 1'b1;
      end else begin
        w_nxt_acc = w_sum;
        w_nxt_cnt = w_cnt_inc;
        if (is_last_in) begin
          w_emit      = 1'b1;
          w_nxt_state = S_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_acc         <= '0;
      r_cnt         <= '0;
      r_grp         <= '0;
      do_en         <= 1'b0;
      data_o        <= '0;
      out_group_num <= '0;
      out_bin_cnt   <= '0;
      frame_done    <= 1'b0;
      proto_err     <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_acc      <= w_nxt_acc;
      r_cnt      <= w_nxt_cnt;
      r_grp      <= w_nxt_grp;
      do_en      <= w_emit;
      proto_err  <= w_err;
      frame_done <= w_emit && (w_nxt_grp == 7'(LAST_GROUP));
      if (w_emit) begin
        data_o        <= w_nxt_acc;
        out_group_num <= w_nxt_grp;
        out_bin_cnt   <= w_nxt_cnt;
      end
    end
  end

  assign dbg_state = r_state;

endmodule

// File: tb/tb_mel_group_accum.sv
// Directed testbench for mel_group_accum: default-parameter instance plus an
// ACC_BW=8 instance sharing the same inputs for the overflow case.
module tb_mel_group_accum;

  localparam int SB_W = 42;  // {frame_done, bin_cnt[9:0], grp[6:0], data[23:0]}

  logic              clk;
  logic              rst;
  logic              di_en;
  logic signed [13:0] data_i;
  logic [9:0]        in_group_idx;
  logic [6:0]        in_group_num;
  logic              is_first_in;
  logic              is_last_in;

  logic              do_en;
  logic [23:0]       data_o;
  logic [6:0]        out_group_num;
  logic [9:0]        out_bin_cnt;
  logic              frame_done;
  logic              proto_err;
  logic [0:0]        dbg_state;

  logic              d8_do_en;
  logic [7:0]        d8_data_o;
  logic [6:0]        d8_out_group_num;
  logic [9:0]        d8_out_bin_cnt;
  logic              d8_frame_done;
  logic              d8_proto_err;
  logic [0:0]        d8_dbg_state;

  int n_checks;
  int n_errors;
  logic [SB_W-1:0] exp_q[$];

  mel_group_accum dut (
    .clk(clk), .rst(rst), .di_en(di_en), .data_i(data_i),
    .in_group_idx(in_group_idx), .in_group_num(in_group_num),
    .is_first_in(is_first_in), .is_last_in(is_last_in),
    .do_en(do_en), .data_o(data_o), .out_group_num(out_group_num),
    .out_bin_cnt(out_bin_cnt), .frame_done(frame_done),
    .proto_err(proto_err), .dbg_state(dbg_state)
  );

  mel_group_accum #(.ACC_BW(8)) dut8 (
    .clk(clk), .rst(rst), .di_en(di_en), .data_i(data_i),
    .in_group_idx(in_group_idx), .in_group_num(in_group_num),
    .is_first_in(is_first_in), .is_last_in(is_last_in),
    .do_en(d8_do_en), .data_o(d8_data_o), .out_group_num(d8_out_group_num),
    .out_bin_cnt(d8_out_bin_cnt), .frame_done(d8_frame_done),
    .proto_err(d8_proto_err), .dbg_state(d8_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic expect_result(input int sum, input int grp, input int cnt);
    logic fd;
    fd = (grp == 88);
    exp_q.push_back({fd, 10'(cnt), 7'(grp), 24'(sum)});
  endtask

  always @(negedge clk) begin
    if (rst && do_en) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_do_en", 64'(do_en), 64'd0);
      end else begin
        logic [SB_W-1:0] e;
        e = exp_q.pop_front();
        check_val("sb_data", 64'(data_o), 64'(e[23:0]));
        check_val("sb_group", 64'(out_group_num), 64'(e[30:24]));
        check_val("sb_bin_cnt", 64'(out_bin_cnt), 64'(e[40:31]));
        check_val("sb_frame_done", 64'(frame_done), 64'(e[41]));
      end
    end else if (rst) begin
      if (frame_done) check_val("frame_done_without_do_en", 64'(frame_done), 64'd0);
    end
  end

  // ---------------- drivers ----------------
  // Called #1 after a rising edge; returns #1 after the next rising edge.
  task automatic send(input int data, input int grp, input bit first, input bit last,
                      input bit exp_err, input bit exp_emit);
    di_en        = 1'b1;
    data_i       = 14'(data);
    in_group_num = 7'(grp);
    in_group_idx = 10'($urandom_range(0, 512));
    is_first_in  = first;
    is_last_in   = last;
    @(posedge clk);
    #1;
    di_en = 1'b0;
    check_val("proto_err", 64'(proto_err), 64'(exp_err));
    check_val("do_en", 64'(do_en), 64'(exp_emit));
  endtask

  // Idle cycle with garbage on the data lines; nothing may happen.
  task automatic idle_cycle();
    di_en        = 1'b0;
    data_i       = 14'sd500;
    in_group_num = 7'd99;
    is_first_in  = 1'b1;
    is_last_in   = 1'b1;
    @(posedge clk);
    #1;
    check_val("idle_do_en", 64'(do_en), 64'd0);
    check_val("idle_proto_err", 64'(proto_err), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    di_en = 1'b0;
    data_i = '0;
    in_group_idx = '0;
    in_group_num = '0;
    is_first_in = 1'b0;
    is_last_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_do_en", 64'(do_en), 64'd0);
    check_val("rst_data_o", 64'(data_o), 64'd0);
    check_val("rst_group", 64'(out_group_num), 64'd0);
    check_val("rst_bin_cnt", 64'(out_bin_cnt), 64'd0);
    check_val("rst_frame_done", 64'(frame_done), 64'd0);
    check_val("rst_proto_err", 64'(proto_err), 64'd0);
    check_val("rst_state", 64'(dbg_state), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Group 5: 10+20+30
    send(10, 5, 1, 0, 0, 0);
    check_val("state_accum", 64'(dbg_state), 64'd1);
    send(20, 5, 0, 0, 0, 0);
    expect_result(60, 5, 3);
    send(30, 5, 0, 1, 0, 1);
    check_val("g5_data", 64'(data_o), 64'd60);
    check_val("state_idle", 64'(dbg_state), 64'd0);
    idle_cycle();
    check_val("hold_data", 64'(data_o), 64'd60);
    check_val("hold_cnt", 64'(out_bin_cnt), 64'd3);

    // Single beat, last group of the frame
    expect_result(7, 88, 1);
    send(7, 88, 1, 1, 0, 1);
    check_val("g88_frame_done", 64'(frame_done), 64'd1);
    idle_cycle();
    check_val("frame_done_pulse", 64'(frame_done), 64'd0);

    // Negative sample counts but adds nothing
    send(100, 10, 1, 0, 0, 0);
    send(-4, 10, 0, 0, 0, 0);
    expect_result(150, 10, 3);
    send(50, 10, 0, 1, 0, 1);
    idle_cycle();

    // Beats without first in IDLE are dropped
    send(99, 2, 0, 0, 1, 0);
    send(99, 2, 0, 1, 1, 0);
    check_val("idle_drop_state", 64'(dbg_state), 64'd0);
    // Group change mid-group is dropped, group continues
    send(5, 2, 1, 0, 0, 0);
    send(1000, 3, 0, 0, 1, 0);
    check_val("mismatch_stay_accum", 64'(dbg_state), 64'd1);
    expect_result(11, 2, 2);
    send(6, 2, 0, 1, 0, 1);
    idle_cycle();

    // Restart: partial group 7 discarded, group 9 loaded
    send(40, 7, 1, 0, 0, 0);
    send(8, 9, 1, 0, 1, 0);
    expect_result(10, 9, 2);
    send(2, 9, 0, 1, 0, 1);
    // Restart with a single-beat group
    send(1, 7, 1, 0, 0, 0);
    expect_result(3, 11, 1);
    send(3, 11, 1, 1, 1, 1);
    idle_cycle();

    // Back-to-back groups, no bubble
    send(1, 1, 1, 0, 0, 0);
    expect_result(3, 1, 2);
    send(2, 1, 0, 1, 0, 1);
    send(3, 2, 1, 0, 0, 0);
    expect_result(7, 2, 2);
    send(4, 2, 0, 1, 0, 1);
    check_val("b2b_data", 64'(data_o), 64'd7);

    // di_en low with garbage on the bus does not accumulate
    send(5, 6, 1, 0, 0, 0);
    idle_cycle();
    expect_result(10, 6, 2);
    send(5, 6, 0, 1, 0, 1);

    // 8-bit accumulator overflow: 200 + 100
    send(200, 4, 1, 0, 0, 0);
    expect_result(300, 4, 2);
    send(100, 4, 0, 1, 0, 1);
    check_val("acc8_do_en", 64'(d8_do_en), 64'd1);
`ifdef MEL_ACC_SAT_EN
    check_val("acc8_data_sat", 64'(d8_data_o), 64'd255);
`else
    check_val("acc8_data_wrap", 64'(d8_data_o), 64'd44);
`endif
    idle_cycle();

    // Bin count saturates at 1023 while the sum keeps growing
    send(1, 20, 1, 0, 0, 0);
    for (int i = 0; i < 1023; i++) send(1, 20, 0, 0, 0, 0);
    expect_result(1025, 20, 1023);
    send(1, 20, 0, 1, 0, 1);
    idle_cycle();

    // Reset mid-group aborts with no output
    send(1, 12, 1, 0, 0, 0);
    send(2, 12, 0, 0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    check_val("abort_data_o", 64'(data_o), 64'd0);
    check_val("abort_state", 64'(dbg_state), 64'd0);
    check_val("abort_cnt", 64'(out_bin_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check_val("abort_do_en", 64'(do_en), 64'd0);
    rst = 1'b1;
    // A continuation beat right after reset is a violation
    send(9, 12, 0, 1, 1, 0);
    send(3, 13, 1, 0, 0, 0);
    expect_result(7, 13, 2);
    send(4, 13, 0, 1, 0, 1);
    check_val("post_rst_data", 64'(data_o), 64'd7);
    check_val("post_rst_cnt", 64'(out_bin_cnt), 64'd2);
    idle_cycle();
    idle_cycle();

    check_val("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
